// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/state types and default widths for the ALU sequencer.
package alu_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_SEL_W = 3;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_LDI} alu_op_e;
    typedef enum logic [2:0] {IDLE, READ_A, READ_B, EXEC, WRITE} seq_state_e;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU producing a WIDTH-bit result and a carry/borrow bit.
module alu_core import alu_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IMM_W = 2 * DEF_SEL_W
) (
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [IMM_W-1:0] imm,
    output logic [WIDTH-1:0] y,
    output logic             c
);
    always_comb begin
        y = '0;
        c = 1'b0;
        case (op)
            OP_ADD: {c, y} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                y = a - b;
                c = a < b;
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_SHL: {c, y} = {a, 1'b0};
            OP_SHR: {y, c} = {1'b0, a};
            OP_LDI: y = WIDTH'(imm);
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: five-state controller reading two operands from a register bank,
// executing one ALU op and writing the result back, self-refreshing on idle cycles.
module alu_sequencer import alu_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       instr_op,
    input  logic [SEL_W-1:0] instr_rd,
    input  logic [SEL_W-1:0] instr_rs1,
    input  logic [SEL_W-1:0] instr_rs2,
    output logic [SEL_W-1:0] rd_sel,
    input  logic [WIDTH-1:0] rd_data,
    output logic [SEL_W-1:0] wr_sel,
    output logic [WIDTH-1:0] wr_data,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_c,
    output logic             busy
);
    seq_state_e state, state_nxt;
    alu_op_e op;
    logic [SEL_W-1:0] rd, rs1, rs2;
    logic [WIDTH-1:0] op_a, op_b, y;
    logic c;

    alu_core #(.WIDTH(WIDTH), .IMM_W(2 * SEL_W)) u_core (
        .op (op),
        .a  (op_a),
        .b  (op_b),
        .imm({rs1, rs2}),
        .y  (y),
        .c  (c)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // The bank write port has no enable: outside WRITE it rewrites the register being read.
    always_comb begin
        state_nxt = state;
        instr_ready = state == IDLE;
        busy = state != IDLE;
        done = state == WRITE;
        rd_sel = state == READ_A ? rs1 : rs2;
        wr_sel = state == WRITE ? rd : rd_sel;
        wr_data = state == WRITE ? result : rd_data;
        case (state)
            IDLE:    state_nxt = instr_valid ? READ_A : IDLE;
            READ_A:  state_nxt = READ_B;
            READ_B:  state_nxt = EXEC;
            EXEC:    state_nxt = WRITE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            op <= OP_ADD;
            rd <= '0;
            rs1 <= '0;
            rs2 <= '0;
            op_a <= '0;
            op_b <= '0;
            result <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            if (state == IDLE && instr_valid) begin
                op <= alu_op_e'(instr_op);
                rd <= instr_rd;
                rs1 <= instr_rs1;
                rs2 <= instr_rs2;
            end
            if (state == READ_A)
                op_a <= rd_data;
            if (state == READ_B)
                op_b <= rd_data;
            if (state == EXEC) begin
                result <= y;
                flag_z <= y == '0;
                flag_c <= c;
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: register-bank environment with scoreboard and arithmetic reference model.
module tb_alu_sequencer;
    logic CLK = 0, RESET = 1, instr_valid = 0;
    logic [2:0] instr_op = 0, instr_rd = 0, instr_rs1 = 0, instr_rs2 = 0;
    logic instr_ready, done, flag_z, flag_c, busy;
    logic [2:0] rd_sel, wr_sel;
    logic [7:0] rd_data, wr_data, result;
    logic [7:0] bank [8];

    typedef struct {int rd; int val; bit z; bit c; int cyc;} exp_t;
    exp_t q[$];
    int ref_regs [8];
    int cyc = 0, busy_until = -1, last_acc = 0, checks = 0, failures = 0;
    int last_res = 0;
    bit last_z = 0, last_c = 0, held = 0;

    alu_sequencer dut (
        .CLK(CLK), .RESET(RESET), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .rd_sel(rd_sel), .rd_data(rd_data), .wr_sel(wr_sel), .wr_data(wr_data),
        .done(done), .result(result), .flag_z(flag_z), .flag_c(flag_c), .busy(busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(posedge CLK) bank[wr_sel] <= wr_data;
    assign rd_data = bank[rd_sel];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int op, input int rs1, input int rs2, input int a, input int b);
        exp_t e;
        int s;
        e.c = 0;
        case (op)
            0: begin s = a + b; e.val = s % 256; e.c = s > 255; end
            1: begin e.val = (a - b + 256) % 256; e.c = a < b; end
            2: e.val = a & b;
            3: e.val = a | b;
            4: e.val = a ^ b;
            5: begin e.val = (a * 2) % 256; e.c = a >= 128; end
            6: begin e.val = a / 2; e.c = (a % 2) == 1; end
            default: e.val = rs1 * 8 + rs2;
        endcase
        e.z = e.val == 0;
        e.rd = 0;
        e.cyc = 0;
        return e;
    endfunction

    // Monitor: handshake timing, self-refresh, done/writeback scoreboard, flag/result hold.
    always @(negedge CLK) begin
        bit exp_ready;
        exp_t e;
        if (!RESET) begin
            exp_ready = cyc > busy_until;
            chk("instr_ready", instr_ready, exp_ready);
            chk("busy", busy, !exp_ready);
            if (done) begin
                if (q.size() == 0)
                    chk("spurious_done", done, 0);
                else begin
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("wr_sel", wr_sel, e.rd);
                    chk("wr_data", wr_data, e.val);
                    chk("result", result, e.val);
                    chk("flag_z", flag_z, e.z);
                    chk("flag_c", flag_c, e.c);
                    last_res = e.val;
                    last_z = e.z;
                    last_c = e.c;
                end
            end else begin
                if (q.size() != 0 && cyc >= q[0].cyc) begin
                    chk("done_missing", done, 1);
                    void'(q.pop_front());
                end
                chk("refresh_sel", wr_sel, rd_sel);
                chk("refresh_data", wr_data, rd_data);
            end
            if (exp_ready) begin
                chk("result_hold", result, last_res);
                chk("flag_z_hold", flag_z, last_z);
                chk("flag_c_hold", flag_c, last_c);
            end
        end
    end

    task automatic issue(input int op, input int rd, input int rs1, input int rs2, input bit hold);
        int t = 0;
        exp_t e;
        @(negedge CLK);
        instr_valid = 1;
        instr_op = 3'(op);
        instr_rd = 3'(rd);
        instr_rs1 = 3'(rs1);
        instr_rs2 = 3'(rs2);
        while (!instr_ready && t < 20) begin
            @(negedge CLK);
            t++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", instr_ready, 1);
            instr_valid = 0;
            held = 0;
            return;
        end
        @(posedge CLK);
        #1;
        if (held)
            chk("b2b_spacing", cyc - last_acc, 5);
        last_acc = cyc;
        busy_until = cyc + 3;
        e = model(op, rs1, rs2, ref_regs[rs1], ref_regs[rs2]);
        e.rd = rd;
        e.cyc = cyc + 3;
        q.push_back(e);
        ref_regs[rd] = e.val;
        held = hold;
        if (!hold)
            instr_valid = 0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((q.size() != 0 || !instr_ready) && t < 50) begin
            @(negedge CLK);
            t++;
        end
        chk("idle_timeout", q.size(), 0);
    endtask

    task automatic check_bank();
        for (int i = 0; i < 8; i++)
            chk($sformatf("bank_r%0d", i), bank[i], ref_regs[i]);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready"}, instr_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_flag_z"}, flag_z, 0);
        chk({tag, "_flag_c"}, flag_c, 0);
        chk({tag, "_rd_sel"}, rd_sel, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit hold;
        for (int i = 0; i < 8; i++) begin
            bank[i] = 0;
            ref_regs[i] = 0;
        end
        repeat (3) @(negedge CLK);
        check_reset_state("reset");
        RESET = 0;
        issue(7, 1, 5, 2, 0);
        wait_idle();
        chk("ldi_r1", bank[1], 'h2A);
        chk("ldi_z", flag_z, 0);
        chk("ldi_c", flag_c, 0);
        issue(7, 2, 7, 4, 0);
        issue(5, 2, 2, 0, 0);
        issue(5, 2, 2, 0, 0);
        issue(7, 3, 4, 0, 0);
        issue(0, 4, 2, 3, 0);
        wait_idle();
        chk("add_r4", bank[4], 'h10);
        chk("add_c", flag_c, 1);
        chk("add_z", flag_z, 0);
        check_bank();
        issue(1, 5, 3, 2, 0);
        wait_idle();
        chk("sub_r5", bank[5], 'h30);
        chk("sub_c", flag_c, 1);
        issue(1, 6, 2, 2, 0);
        wait_idle();
        chk("sub_r6", bank[6], 0);
        chk("sub_z", flag_z, 1);
        chk("sub_c0", flag_c, 0);
        issue(7, 2, 4, 0, 0);
        issue(5, 2, 2, 0, 0);
        issue(5, 2, 2, 0, 0);
        issue(7, 0, 0, 1, 0);
        issue(3, 2, 2, 0, 0);
        issue(5, 1, 2, 0, 0);
        wait_idle();
        chk("shl_r1", bank[1], 'h02);
        chk("shl_c", flag_c, 1);
        issue(6, 1, 2, 0, 0);
        wait_idle();
        chk("shr_r1", bank[1], 'h40);
        chk("shr_c", flag_c, 1);
        issue(7, 2, 0, 5, 0);
        issue(0, 2, 2, 2, 0);
        wait_idle();
        chk("alias_r2", bank[2], 'h0A);
        check_bank();
        issue(0, 3, 1, 2, 1);
        issue(4, 4, 3, 1, 1);
        issue(6, 5, 4, 0, 0);
        wait_idle();
        check_bank();
        issue(0, 7, 1, 2, 0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1;
        void'(q.pop_back());
        ref_regs[7] = 0;
        busy_until = -1;
        held = 0;
        last_res = 0;
        last_z = 0;
        last_c = 0;
        @(negedge CLK);
        check_reset_state("midreset");
        RESET = 0;
        @(negedge CLK);
        chk("ready_after_reset", instr_ready, 1);
        check_bank();
        for (int i = 0; i < 40; i++) begin
            hold = ($urandom_range(0, 2) == 0) && (i < 39);
            issue($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), hold);
            if (!hold)
                repeat ($urandom_range(0, 2)) @(negedge CLK);
        end
        wait_idle();
        check_bank();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
